// File: rtl/mem_ctrl_if.sv
// mem_ctrl client/RAM bundle: LSB and fetch requests plus the 8-bit RAM/IO port.
// The master drives requests and RAM read data; the slave is the controller.
interface mem_ctrl_if;
  logic [31:0] lsb_oprand;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_data;
  logic [1:0]  ready;
  logic [31:0] mem_data;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        flush;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    output lsb_oprand, lsb_addr, lsb_data,
    output if_req, if_addr, flush,
    output mem_din, io_buffer_full,
    input  ready, mem_data, if_done, if_inst,
    input  mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  lsb_oprand, lsb_addr, lsb_data,
    input  if_req, if_addr, flush,
    input  mem_din, io_buffer_full,
    output ready, mem_data, if_done, if_inst,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: LSB loads/stores and instruction fetch
// over one 8-bit RAM/IO port, with IO store stall and flush handling.
module mem_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  mem_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
  localparam logic [6:0] OP_ST = 7'b0100011;

  state_t      state, state_d, eff;
  logic [2:0]  cnt, cnt_d, e_cnt, n;
  logic [31:0] base, base_d, e_base;
  logic [31:0] wdat, wdat_d, e_data;
  logic [2:0]  f3, f3_d, e_f3;

  logic        slot_v, slot_v_d;
  logic        slot_st, slot_st_d;
  logic        slot_sup, slot_sup_d;
  logic [31:0] slot_addr, slot_addr_d;
  logic [31:0] slot_data, slot_data_d;
  logic [2:0]  slot_f3, slot_f3_d;

  logic [31:0] acc, acc_d;
  logic        ready1, ready1_d;
  logic        done_r, done_d;
  logic [31:0] mdata_r, mdata_d;
  logic [31:0] inst_r, inst_d;
  logic [31:0] a_r, a_d;
  logic [7:0]  dout_r, dout_d;
  logic        wr_r, wr_d;

  logic        req, req_st, take;
  logic        stall, issue, last_ld, st_done, fin_ld;
  logic        is_rd;
  logic [1:0]  idx;

  assign req    = |bus.lsb_oprand;
  assign req_st = bus.lsb_oprand[6:0] == OP_ST;
  assign take   = req && !bus.flush && !slot_v;

  function automatic logic [31:0] ext(
    input logic [31:0] a,
    input logic [2:0]  f
  );
    case (f)
      3'b000:  ext = {{24{a[7]}}, a[7:0]};
      3'b001:  ext = {{16{a[15]}}, a[15:0]};
      3'b100:  ext = {24'd0, a[7:0]};
      3'b101:  ext = {16'd0, a[15:0]};
      default: ext = a;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      base      <= 32'd0;
      wdat      <= 32'd0;
      f3        <= 3'd0;
      slot_v    <= 1'b0;
      slot_st   <= 1'b0;
      slot_sup  <= 1'b0;
      slot_addr <= 32'd0;
      slot_data <= 32'd0;
      slot_f3   <= 3'd0;
      acc       <= 32'd0;
      ready1    <= 1'b0;
      done_r    <= 1'b0;
      mdata_r   <= 32'd0;
      inst_r    <= 32'd0;
      a_r       <= 32'd0;
      dout_r    <= 8'd0;
      wr_r      <= 1'b0;
    end else if (rdy) begin
      state     <= state_d;
      cnt       <= cnt_d;
      base      <= base_d;
      wdat      <= wdat_d;
      f3        <= f3_d;
      slot_v    <= slot_v_d;
      slot_st   <= slot_st_d;
      slot_sup  <= slot_sup_d;
      slot_addr <= slot_addr_d;
      slot_data <= slot_data_d;
      slot_f3   <= slot_f3_d;
      acc       <= acc_d;
      ready1    <= ready1_d;
      done_r    <= done_d;
      mdata_r   <= mdata_d;
      inst_r    <= inst_d;
      a_r       <= a_d;
      dout_r    <= dout_d;
      wr_r      <= wr_d;
    end
  end

  // From IDLE the starting op is decoded in the same cycle, so the
  // first byte goes out on the acceptance edge.
  always_comb begin
    eff    = state;
    e_cnt  = cnt;
    e_base = base;
    e_data = wdat;
    e_f3   = f3;
    if (state == IDLE) begin
      e_cnt = 3'd0;
      if (slot_v && !(bus.flush && !slot_st)) begin
        eff    = slot_st ? STORE : LOAD;
        e_base = slot_addr;
        e_data = slot_data;
        e_f3   = slot_f3;
      end else if (take) begin
        eff    = req_st ? STORE : LOAD;
        e_base = bus.lsb_addr;
        e_data = bus.lsb_data;
        e_f3   = bus.lsb_oprand[14:12];
      end else if (bus.if_req && !bus.flush) begin
        eff    = FETCH;
        e_base = bus.if_addr;
        e_data = 32'd0;
        e_f3   = 3'b010;
      end
    end
    case (e_f3[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    is_rd   = (eff == LOAD) || (eff == FETCH);
    stall   = (eff == STORE) && (e_base[17:16] == 2'b11)
              && bus.io_buffer_full;
    last_ld = is_rd && (e_cnt == n + 3'd1);
    st_done = (eff == STORE) && (e_cnt == n);
    issue   = (eff != IDLE) && (e_cnt < n) && !stall
              && !(bus.flush && eff != STORE);
    state_d = eff;
    if (last_ld || st_done || (bus.flush && eff != STORE))
      state_d = IDLE;
    if (state_d == IDLE)
      cnt_d = 3'd0;
    else if (eff == STORE)
      cnt_d = e_cnt + {2'd0, issue};
    else
      cnt_d = e_cnt + 3'd1;
  end

  always_comb begin
    base_d = e_base;
    wdat_d = e_data;
    f3_d   = e_f3;
    a_d    = 32'd0;
    wr_d   = 1'b0;
    dout_d = 8'd0;
    if (issue) begin
      a_d = e_base + {29'd0, e_cnt};
      if (eff == STORE) begin
        wr_d = 1'b1;
        case (e_cnt[1:0])
          2'd0:    dout_d = e_data[7:0];
          2'd1:    dout_d = e_data[15:8];
          2'd2:    dout_d = e_data[23:16];
          default: dout_d = e_data[31:24];
        endcase
      end
    end
    // Read data lags its address by two edges.
    idx   = e_cnt[1:0] - 2'd2;
    acc_d = (state == IDLE) ? 32'd0 : acc;
    if (is_rd && e_cnt >= 3'd2)
      acc_d[{idx, 3'b000} +: 8] = bus.mem_din;
    fin_ld   = last_ld && !bus.flush;
    ready1_d = 1'b0;
    done_d   = 1'b0;
    mdata_d  = mdata_r;
    inst_d   = inst_r;
    if (fin_ld && eff == FETCH) begin
      done_d = 1'b1;
      inst_d = acc_d;
    end
    if (fin_ld && eff == LOAD) begin
      ready1_d = 1'b1;
      mdata_d  = ext(acc_d, e_f3);
    end
    if (st_done && !slot_sup && !bus.flush) begin
      ready1_d = 1'b1;
      mdata_d  = 32'd0;
    end
    slot_v_d    = slot_v;
    slot_st_d   = slot_st;
    slot_sup_d  = slot_sup;
    slot_addr_d = slot_addr;
    slot_data_d = slot_data;
    slot_f3_d   = slot_f3;
    if (take) begin
      slot_v_d    = 1'b1;
      slot_st_d   = req_st;
      slot_sup_d  = 1'b0;
      slot_addr_d = bus.lsb_addr;
      slot_data_d = bus.lsb_data;
      slot_f3_d   = bus.lsb_oprand[14:12];
    end
    if (bus.flush && slot_v) begin
      if (slot_st) slot_sup_d = 1'b1;
      else         slot_v_d   = 1'b0;
    end
    if ((fin_ld && eff == LOAD) || st_done) begin
      slot_v_d   = 1'b0;
      slot_sup_d = 1'b0;
    end
  end

  assign bus.ready    = {ready1, ~slot_v};
  assign bus.mem_data = mdata_r;
  assign bus.if_done  = done_r;
  assign bus.if_inst  = inst_r;
  assign bus.mem_a    = a_r;
  assign bus.mem_dout = dout_r;
  assign bus.mem_wr   = wr_r;
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the core and the 8-bit unified RAM/IO port. It serves two clients: the load/store buffer (32-bit operand/addr/data request, `ready[1:0]` status, `mem_data` result) and instruction fetch (level request, 32-bit word return). It performs LB/LH/LW/LBU/LHU/SB/SH/SW as 1–4 sequential byte transactions, stalls IO stores on `io_buffer_full`, and handles pipeline flush.

## Interface
- No parameters.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  clock enable; when low all state and outputs hold
- lsb_oprand  in  32  LSB request; nonzero means valid (bit 20 forced to 1 by requester); [6:0] opcode (0000011 load, 0100011 store); [14:12] funct3
- lsb_addr  in  32  byte address
- lsb_data  in  32  store data; low bytes used
- ready  out  2  [0]=LSB side free; [1]=one-cycle completion pulse
- mem_data  out  32  load result, extended per funct3, valid with ready[1]
- if_req  in  1  fetch request (level, held until if_done)
- if_addr  in  32  fetch address (word aligned)
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched word, little-endian
- flush  in  1  misprediction flush
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1=write, 0=read
- io_buffer_full  in  1  UART buffer full

## Operation
- Pending slot (1 entry): any cycle with lsb_oprand≠0 captures {oprand, addr, data} into the slot. ready[0]=0 from the capture edge until the completion edge. A request arriving while ready[0]=0 is a protocol error (not handled).
- States: IDLE, FETCH, LOAD, STORE; byte counter cnt[2:0]; length n = 1/2/4 from funct3[1:0].
- IDLE: pending slot valid → LOAD/STORE (LSB has priority); else if_req && !flush → FETCH (n=4); else stay.
- Byte k address = base+k (32-bit wrap). Loads/fetch: mem_wr=0. Stores: mem_dout = data[8k+7:8k], mem_wr=1.
- Result assembly little-endian. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW unchanged.
- IO stall: store with addr[17:16]==2'b11 while io_buffer_full=1 → no byte issued (mem_wr=0, mem_a=0), cnt frozen; resumes the cycle after it drops.
- Completion: LOAD/STORE → ready[1]=1 for one cycle, mem_data updated (stores: mem_data=0), slot cleared, ready[0]=1, state IDLE. FETCH → if_done=1, if_inst set, state IDLE.
- Flush (sampled at edge): FETCH aborted → IDLE, no if_done. LOAD in flight or pending load discarded, no ready[1]. STORE in flight or pending runs to completion, but its ready[1] is suppressed. ready[0] returns to 1 once no LSB op remains. Flush concurrent with an LSB request: the request is dropped.
- Idle outputs: mem_a=0, mem_wr=0, mem_dout=0.

## Timing
- Reset (async): state IDLE, cnt=0, slot empty, ready=2'b01, mem_data=0, if_done=0, if_inst=0, mem_a=0, mem_dout=0, mem_wr=0.
- All outputs registered. RAM: address in cycle c → mem_din valid in cycle c+1.
- Request sampled at edge E0 (slot→state at the same edge if IDLE). Byte k driven in cycle after E0+k.
- Load/fetch of n bytes: last byte captured at E0+n+1; ready[1]/if_done visible in the following cycle. LW = 5 edges from acceptance.
- Store of n bytes: completion registered at E0+n (plus stall cycles).
- LSB request captured during a FETCH waits; it starts at the edge after if_done is registered. Back-to-back: a new operation may start at the edge after completion.

## Test plan
- LW addr 0x100, RAM bytes 11 22 33 44 → mem_a 0x100..0x103 on consecutive cycles; ready[1] pulse with mem_data=0x44332211, 5 edges after acceptance.
- LB addr 0x200 = 0x80 → mem_data=0xFFFFFF80; LBU → 0x00000080; LH 0x8001 → 0xFFFF8001.
- SH addr 0x300, data 0xDEADBEEF → writes EF@0x300, BE@0x301, only two mem_wr cycles; ready[1] pulse; ready[0] 0 during, 1 after.
- SB to 0x30000 with io_buffer_full high for 3 cycles → mem_wr low those cycles, single write of the byte afterwards.
- if_req at 0x1000 while LSB issues LW at the same cycle → LW first, then fetch; if_done with if_inst correct.
- Flush mid-LW (after byte 1) → no ready[1], state IDLE, ready[0]=1 next cycle; flush mid-SW → all 4 bytes still written, no ready[1].
